// File: rtl/breakout_pkg.sv
// Shared constants, FSM encoding and brick/score helpers for the breakout wall logic.
package breakout_pkg;
   localparam int ROWS    = 4;
   localparam int COLS    = 8;
   localparam int SCORE_W = 14;
   localparam int ROW_W   = $clog2(ROWS);
   localparam int BRK_W   = $clog2(COLS);

   typedef enum logic [1:0] {S_IDLE, S_APPLY, S_CLEARED, S_RELOAD} state_t;

   function automatic int brick_idx(input int row, input int brk, input int cols);
      return row * cols + brk;
   endfunction

   // Top rows sit furthest from the paddle, so they are worth the most.
   function automatic int points(input int row, input int rows);
      return rows - row;
   endfunction
endpackage

// File: rtl/brick_score_acc.sv
// Saturating score accumulator: adds add_val when add_en, pins at all ones.
module brick_score_acc #(
   parameter int SCORE_W = 14,
   parameter int VAL_W   = 3
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               add_en,
   input  logic [VAL_W-1:0]   add_val,
   output logic [SCORE_W-1:0] score
);
   logic [SCORE_W-1:0] r_score;
   logic [SCORE_W:0]   w_sum;

   assign w_sum = {1'b0, r_score} + (SCORE_W+1)'(add_val);

   always_ff @(posedge clk) begin
      if (rst)
         r_score <= '0;
      else if (add_en)
         r_score <= w_sum[SCORE_W] ? '1 : w_sum[SCORE_W-1:0];
   end

   assign score = r_score;
endmodule

// File: rtl/brick_hit_handler.sv
// Owns the brick wall: applies hit reports, scores them, pulses bounce, handles level clear/reload.
module brick_hit_handler #(
   parameter int ROWS    = breakout_pkg::ROWS,
   parameter int COLS    = breakout_pkg::COLS,
   parameter int SCORE_W = breakout_pkg::SCORE_W,
   parameter int ROW_W   = $clog2(ROWS),
   parameter int BRK_W   = $clog2(COLS)
)(
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             hit_valid,
   input  logic [ROW_W-1:0]                 hit_row,
   input  logic [BRK_W-1:0]                 hit_brk,
   input  logic                             new_level,
   output logic                             ready,
   output logic [ROWS*COLS-1:0]             bricks,
   output logic                             bounce,
   output logic [SCORE_W-1:0]               score,
   output logic [$clog2(ROWS*COLS+1)-1:0]   bricks_left,
   output logic                             level_clear
);
   import breakout_pkg::*;

   localparam int NB     = ROWS * COLS;
   localparam int LEFT_W = $clog2(NB + 1);
   localparam int IDX_W  = $clog2(NB);

   state_t              r_state;
   logic [ROW_W-1:0]    r_row;
   logic [BRK_W-1:0]    r_brk;
   logic [NB-1:0]       r_bricks;
   logic [LEFT_W-1:0]   r_left;
   logic                r_bounce;
   logic                r_ready;
   logic                r_lvl;

   logic [IDX_W-1:0]    w_idx;
   logic                w_in_range;
   logic                w_hit;
   logic [ROW_W:0]      w_pts;

   assign w_idx      = IDX_W'(brick_idx(int'(r_row), int'(r_brk), COLS));
   assign w_in_range = (int'(r_row) < ROWS) && (int'(r_brk) < COLS);
   // Stale or duplicate hits land on an already-cleared bit and fall through silently.
   assign w_hit      = (r_state == S_APPLY) && w_in_range && r_bricks[w_idx];
   assign w_pts      = (ROW_W+1)'(points(int'(r_row), ROWS));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_row    <= '0;
         r_brk    <= '0;
         r_bricks <= '1;
         r_left   <= LEFT_W'(NB);
         r_bounce <= 1'b0;
         r_ready  <= 1'b1;
         r_lvl    <= 1'b0;
      end else begin
         r_bounce <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (hit_valid) begin
                  r_row   <= hit_row;
                  r_brk   <= hit_brk;
                  r_ready <= 1'b0;
                  r_state <= S_APPLY;
               end
            end
            S_APPLY: begin
               r_ready <= 1'b1;
               r_state <= S_IDLE;
               if (w_hit) begin
                  r_bricks[w_idx] <= 1'b0;
                  r_left          <= r_left - LEFT_W'(1);
                  r_bounce        <= 1'b1;
                  if (r_left == LEFT_W'(1)) begin
                     r_ready <= 1'b0;
                     r_lvl   <= 1'b1;
                     r_state <= S_CLEARED;
                  end
               end
            end
            S_CLEARED: begin
               if (new_level)
                  r_state <= S_RELOAD;
            end
            S_RELOAD: begin
               r_bricks <= '1;
               r_left   <= LEFT_W'(NB);
               r_lvl    <= 1'b0;
               r_ready  <= 1'b1;
               r_state  <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   brick_score_acc #(
      .SCORE_W (SCORE_W),
      .VAL_W   (ROW_W + 1)
   ) u_score (
      .clk     (clk),
      .rst     (rst),
      .add_en  (w_hit),
      .add_val (w_pts),
      .score   (score)
   );

   assign ready       = r_ready;
   assign bricks      = r_bricks;
   assign bounce      = r_bounce;
   assign bricks_left = r_left;
   assign level_clear = r_lvl;
endmodule

// File: tb/tb_brick_hit_handler.sv
// Self-checking bench: directed table, transaction-level wall model with random hits, reset and saturation corners.
module tb_brick_hit_handler;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        hit_valid = 1'b0;
   logic [1:0]  hit_row = '0;
   logic [2:0]  hit_brk = '0;
   logic        new_level = 1'b0;
   logic        ready, bounce, level_clear;
   logic [31:0] bricks;
   logic [13:0] score;
   logic [5:0]  bricks_left;

   logic        s_valid = 1'b0;
   logic [1:0]  s_row = '0;
   logic [2:0]  s_brk = '0;
   logic        s_new_level = 1'b0;
   logic        s_ready, s_bounce, s_lc;
   logic [31:0] s_bricks;
   logic [3:0]  s_score;
   logic [5:0]  s_left;

   int n_cmp = 0;
   int n_err = 0;

   // Transaction-level model: wall as a bit vector, score as a plain integer.
   logic [31:0] m_bricks;
   int          m_score;
   bit          m_lc;

   always #5 clk = ~clk;

   brick_hit_handler u_dut (
      .clk(clk), .rst(rst), .hit_valid(hit_valid), .hit_row(hit_row), .hit_brk(hit_brk),
      .new_level(new_level), .ready(ready), .bricks(bricks), .bounce(bounce),
      .score(score), .bricks_left(bricks_left), .level_clear(level_clear)
   );

   brick_hit_handler #(.SCORE_W(4)) u_sat (
      .clk(clk), .rst(rst), .hit_valid(s_valid), .hit_row(s_row), .hit_brk(s_brk),
      .new_level(s_new_level), .ready(s_ready), .bricks(s_bricks), .bounce(s_bounce),
      .score(s_score), .bricks_left(s_left), .level_clear(s_lc)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_bricks = '1;
      m_score  = 0;
      m_lc     = 1'b0;
   endtask

   task automatic check_state(input string nm, input bit exp_bounce);
      chk({nm, ".bricks"}, 64'(bricks), 64'(m_bricks));
      chk({nm, ".score"}, 64'(score), 64'(m_score));
      chk({nm, ".left"}, 64'(bricks_left), 64'($countones(m_bricks)));
      chk({nm, ".ready"}, 64'(ready), 64'(!m_lc));
      chk({nm, ".lc"}, 64'(level_clear), 64'(m_lc));
      chk({nm, ".bounce"}, 64'(bounce), 64'(exp_bounce));
   endtask

   // Called at a negedge with the DUT idle. Returns whether the brick was destroyed.
   task automatic do_hit(input int row, input int brk, input bit hold, output bit present);
      int idx;
      idx = row * 8 + brk;
      hit_valid = 1'b1;
      hit_row   = 2'(row);
      hit_brk   = 3'(brk);
      @(negedge clk);
      if (!hold) hit_valid = 1'b0;
      chk("apply.ready", 64'(ready), 64'(0));
      chk("apply.bounce", 64'(bounce), 64'(0));
      present = m_bricks[idx];
      if (present) begin
         m_bricks[idx] = 1'b0;
         m_score = m_score + (4 - row);
         if (m_score > 16383) m_score = 16383;
      end
      m_lc = (m_bricks == 32'd0);
      @(negedge clk);
      hit_valid = 1'b0;
      check_state("hit", present);
   endtask

   task automatic do_reload();
      new_level = 1'b1;
      @(negedge clk);
      new_level = 1'b0;
      @(negedge clk);
      m_bricks = '1;
      m_lc     = 1'b0;
      check_state("reload", 1'b0);
   endtask

   task automatic do_reset(input string nm);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      check_state(nm, 1'b0);
   endtask

   task automatic clear_wall();
      bit p;
      for (int r = 3; r >= 0; r--)
         for (int b = 0; b < 8; b++)
            do_hit(r, b, 1'b0, p);
   endtask

   task automatic sat_hit(input int row, input int brk, input int exp);
      s_valid = 1'b1;
      s_row   = 2'(row);
      s_brk   = 3'(brk);
      @(negedge clk);
      s_valid = 1'b0;
      @(negedge clk);
      chk("sat.score", 64'(s_score), 64'(exp));
      chk("sat.bounce", 64'(s_bounce), 64'(1));
   endtask

   typedef struct {
      int row; int brk; bit hold;
      int exp_score; int exp_left; bit exp_bounce;
   } vec_t;

   initial begin
      vec_t tbl[6];
      bit   p;
      tbl[0] = '{0, 5, 1'b0, 4, 31, 1'b1};
      tbl[1] = '{0, 5, 1'b1, 4, 31, 1'b0};
      tbl[2] = '{3, 0, 1'b0, 5, 30, 1'b1};
      tbl[3] = '{1, 7, 1'b1, 8, 29, 1'b1};
      tbl[4] = '{2, 2, 1'b0, 10, 28, 1'b1};
      tbl[5] = '{1, 7, 1'b0, 10, 28, 1'b0};

      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check_state("idle", 1'b0);
         @(negedge clk);
      end

      for (int i = 0; i < 6; i++) begin
         do_hit(tbl[i].row, tbl[i].brk, tbl[i].hold, p);
         chk("tbl.score", 64'(score), 64'(tbl[i].exp_score));
         chk("tbl.left", 64'(bricks_left), 64'(tbl[i].exp_left));
         chk("tbl.bounce", 64'(bounce), 64'(tbl[i].exp_bounce));
         @(negedge clk);
         chk("tbl.bounce_off", 64'(bounce), 64'(0));
         chk("tbl.ready", 64'(ready), 64'(1));
      end

      // new_level while idle must not touch the wall.
      new_level = 1'b1;
      @(negedge clk);
      new_level = 1'b0;
      @(negedge clk);
      check_state("nl_idle", 1'b0);

      do_reset("reset2");
      clear_wall();
      chk("clear.score", 64'(score), 64'(80));
      chk("clear.lc", 64'(level_clear), 64'(1));
      hit_valid = 1'b1;
      hit_row   = 2'd0;
      hit_brk   = 3'd0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_state("cleared_ignore", 1'b0);
      end
      hit_valid = 1'b0;
      do_reload();
      chk("reload.score", 64'(score), 64'(80));
      chk("reload.bricks", 64'(bricks), 64'(32'hFFFF_FFFF));

      for (int i = 0; i < 120; i++) begin
         do_hit(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), p);
         @(negedge clk);
         check_state("rnd_gap", 1'b0);
         if (m_lc) do_reload();
      end

      // Reset lands on the APPLY cycle: the captured hit must be discarded.
      do_reset("reset3");
      hit_valid = 1'b1;
      hit_row   = 2'd1;
      hit_brk   = 3'd3;
      @(negedge clk);
      hit_valid = 1'b0;
      chk("rst_apply.ready", 64'(ready), 64'(0));
      do_reset("rst_apply");
      @(negedge clk);
      check_state("rst_apply_post", 1'b0);

      clear_wall();
      chk("pre_rst_cleared.lc", 64'(level_clear), 64'(1));
      @(negedge clk);
      do_reset("rst_cleared");
      @(negedge clk);
      check_state("rst_cleared_post", 1'b0);

      sat_hit(0, 0, 4);
      sat_hit(0, 1, 8);
      sat_hit(0, 2, 12);
      sat_hit(2, 0, 14);
      sat_hit(0, 3, 15);
      sat_hit(0, 4, 15);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
